// File: rtl/ethernet_smi_pkg.sv
// Shared types and constants for the Clause 22 SMI/MDIO responder:
// decoder state encoding, frame field codes and field widths.
package ethernet_smi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA
  } smi_state_e;

  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  // The preamble counter must not wrap, or a long idle run could look short.
  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

endpackage

// File: rtl/ethernet_smi_responder_if.sv
// Management bus between an SMI master / register bank and the responder:
// MDC/MDIO pad signals plus the register-bank strobe side.
interface ethernet_smi_responder_if;
  import ethernet_smi_pkg::*;

  logic               mdc;
  logic               mdio_i;
  logic               mdio_o;
  logic               mdio_oe;
  logic [REGAD_W-1:0] reg_addr;
  logic [DATA_W-1:0]  reg_wdata;
  logic               reg_we;
  logic               reg_re;
  logic [DATA_W-1:0]  reg_rdata;
  logic               frame_active;

  modport slave (
    input  mdc, mdio_i, reg_rdata,
    output mdio_o, mdio_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_active
  );

  modport master (
    output mdc, mdio_i, reg_rdata,
    input  mdio_o, mdio_oe, reg_addr, reg_wdata, reg_we, reg_re, frame_active
  );
endinterface

// File: rtl/ethernet_smi_sync.sv
// Brings MDC/MDIO into the clk domain and produces a one-clk tick per MDC
// rising edge; tick lands 3 clk after the pad edge.
module ethernet_smi_sync (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  input  logic mdio_i,
  output logic tick,
  output logic mdio_s
);

  logic [1:0] mdc_sync_q, mdc_sync_d;
  logic [1:0] mdio_sync_q, mdio_sync_d;
  logic       mdc_prev_q, mdc_prev_d;
  logic       tick_q, tick_d;

  always_comb begin
    mdc_sync_d  = {mdc_sync_q[0], mdc};
    mdio_sync_d = {mdio_sync_q[0], mdio_i};
    mdc_prev_d  = mdc_sync_q[1];
    tick_d      = mdc_sync_q[1] & ~mdc_prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      mdc_prev_q  <= mdc_prev_d;
      tick_q      <= tick_d;
    end
  end

  assign tick   = tick_q;
  assign mdio_s = mdio_sync_q[1];

endmodule

// File: rtl/ethernet_smi_responder.sv
// Clause 22 SMI/MDIO PHY-side responder: decodes frames into register strobes
// and drives read data back on MDIO. Define SMI_PREAMBLE_SUPPRESS_EN to accept
// a frame after a single preamble 1.
module ethernet_smi_responder
  import ethernet_smi_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'h01,
  parameter int                 PREAMBLE_MIN = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  ethernet_smi_responder_if.slave smi
);

`ifdef SMI_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] PRE_THRESH = 6'd1;
`else
  localparam logic [5:0] PRE_THRESH = 6'(PREAMBLE_MIN);
`endif

  logic tick;
  logic mdio_s;

  ethernet_smi_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .mdc    (smi.mdc),
    .mdio_i (smi.mdio_i),
    .tick   (tick),
    .mdio_s (mdio_s)
  );

  smi_state_e         state_q, state_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [5:0]         ones_cnt_q, ones_cnt_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic               is_read_q, is_read_d;
  logic               mismatch_q, mismatch_d;
  logic               mdio_o_q, mdio_o_d;
  logic               mdio_oe_q, mdio_oe_d;
  logic [REGAD_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]  reg_wdata_q, reg_wdata_d;
  logic               reg_we_q, reg_we_d;
  logic               reg_re_q, reg_re_d;
  logic               frame_active_q, frame_active_d;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    ones_cnt_d     = ones_cnt_q;
    sh_d           = sh_q;
    is_read_d      = is_read_q;
    mismatch_d     = mismatch_q;
    mdio_o_d       = mdio_o_q;
    mdio_oe_d      = mdio_oe_q;
    reg_addr_d     = reg_addr_q;
    reg_wdata_d    = reg_wdata_q;
    reg_we_d       = 1'b0;
    reg_re_d       = 1'b0;
    frame_active_d = frame_active_q;

    // Read data arrives one clk after the strobe, long before the TA bit 2 tick.
    if (reg_re_q) begin
      sh_d = smi.reg_rdata;
    end

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (mdio_s != ST[1]) begin
            ones_cnt_d = sat_inc6(ones_cnt_q);
          end else if (ones_cnt_q >= PRE_THRESH) begin
            state_d        = S_ST;
            frame_active_d = 1'b1;
            ones_cnt_d     = '0;
          end else begin
            ones_cnt_d = '0;
          end
        end
        S_ST: begin
          bit_cnt_d = '0;
          if (mdio_s == ST[0]) begin
            state_d = S_OP;
          end else begin
            state_d        = S_IDLE;
            frame_active_d = 1'b0;
          end
        end
        S_OP: begin
          sh_d = {sh_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = '0;
            if ({sh_q[0], mdio_s} == OP_READ) begin
              is_read_d = 1'b1;
              state_d   = S_PHYAD;
            end else if ({sh_q[0], mdio_s} == OP_WRITE) begin
              is_read_d = 1'b0;
              state_d   = S_PHYAD;
            end else begin
              state_d        = S_IDLE;
              frame_active_d = 1'b0;
            end
          end
        end
        S_PHYAD: begin
          sh_d = {sh_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'(PHYAD_W - 1)) begin
            mismatch_d = ({sh_q[PHYAD_W-2:0], mdio_s} != PHY_ADDR);
            bit_cnt_d  = '0;
            state_d    = S_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_REGAD: begin
          sh_d = {sh_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'(REGAD_W - 1)) begin
            reg_addr_d = {sh_q[REGAD_W-2:0], mdio_s};
            bit_cnt_d  = '0;
            if (mismatch_q) begin
              state_d        = S_IDLE;
              frame_active_d = 1'b0;
            end else begin
              reg_re_d = is_read_q;
              state_d  = S_TA;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_TA: begin
          if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
            if (is_read_q) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
            end
          end else begin
            bit_cnt_d = '0;
            if (is_read_q) begin
              mdio_o_d = sh_q[DATA_W-1];
              sh_d     = {sh_q[DATA_W-2:0], 1'b0};
              state_d  = S_RDATA;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          sh_d = {sh_q[DATA_W-2:0], mdio_s};
          if (bit_cnt_q == 5'(DATA_W - 1)) begin
            reg_wdata_d    = {sh_q[DATA_W-2:0], mdio_s};
            reg_we_d       = 1'b1;
            bit_cnt_d      = '0;
            state_d        = S_IDLE;
            frame_active_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        S_RDATA: begin
          // The tick that samples bit 0 is the 16th in this state.
          if (bit_cnt_q == 5'(DATA_W - 1)) begin
            mdio_oe_d      = 1'b0;
            mdio_o_d       = 1'b0;
            bit_cnt_d      = '0;
            state_d        = S_IDLE;
            frame_active_d = 1'b0;
          end else begin
            mdio_o_d  = sh_q[DATA_W-1];
            sh_d      = {sh_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: begin
          state_d        = S_IDLE;
          bit_cnt_d      = '0;
          ones_cnt_d     = '0;
          mdio_oe_d      = 1'b0;
          mdio_o_d       = 1'b0;
          frame_active_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      ones_cnt_q     <= '0;
      sh_q           <= '0;
      is_read_q      <= 1'b0;
      mismatch_q     <= 1'b0;
      mdio_o_q       <= 1'b0;
      mdio_oe_q      <= 1'b0;
      reg_addr_q     <= '0;
      reg_wdata_q    <= '0;
      reg_we_q       <= 1'b0;
      reg_re_q       <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      ones_cnt_q     <= ones_cnt_d;
      sh_q           <= sh_d;
      is_read_q      <= is_read_d;
      mismatch_q     <= mismatch_d;
      mdio_o_q       <= mdio_o_d;
      mdio_oe_q      <= mdio_oe_d;
      reg_addr_q     <= reg_addr_d;
      reg_wdata_q    <= reg_wdata_d;
      reg_we_q       <= reg_we_d;
      reg_re_q       <= reg_re_d;
      frame_active_q <= frame_active_d;
    end
  end

  assign smi.mdio_o       = mdio_o_q;
  assign smi.mdio_oe      = mdio_oe_q;
  assign smi.reg_addr     = reg_addr_q;
  assign smi.reg_wdata    = reg_wdata_q;
  assign smi.reg_we       = reg_we_q;
  assign smi.reg_re       = reg_re_q;
  assign smi.frame_active = frame_active_q;

endmodule

// File: tb/tb_ethernet_smi_responder.sv
// Directed bench for ethernet_smi_responder: acts as the SMI master and as a
// register bank, driving MDC at 10 clk per bit.
`timescale 1ns/1ps
module tb_ethernet_smi_responder;
  import ethernet_smi_pkg::*;

  typedef struct {
    string       name;
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] data;
    int          exp_we;
    int          exp_re;
    logic [4:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m_drive = 1'b1;
  logic [15:0] rd_value = 16'h0000;

  int n_cmp = 0;
  int n_fail = 0;

  int          we_cnt = 0;
  int          re_cnt = 0;
  int          oe_cnt = 0;
  int          both_cnt = 0;
  logic [4:0]  we_addr = '0;
  logic [4:0]  re_addr = '0;
  logic [15:0] we_data = '0;

  always #5 clk = ~clk;

  ethernet_smi_responder_if bus ();

  // Pad model: the responder wins when it drives, otherwise the master or a pull-up.
  assign bus.mdio_i = bus.mdio_oe ? bus.mdio_o : m_drive;

  ethernet_smi_responder #(
    .PHY_ADDR     (5'h01),
    .PREAMBLE_MIN (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .smi   (bus.slave)
  );

  // Register-bank side: valid read data only in the clk right after reg_re.
  always @(negedge clk) begin
    if (bus.reg_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = bus.reg_addr;
      we_data = bus.reg_wdata;
    end
    if (bus.reg_re) begin
      re_cnt  = re_cnt + 1;
      re_addr = bus.reg_addr;
    end
    if (bus.reg_we && bus.reg_re) both_cnt = both_cnt + 1;
    if (bus.mdio_oe) oe_cnt = oe_cnt + 1;
    bus.reg_rdata = bus.reg_re ? rd_value : 16'hDEAD;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mdcBit(input logic b);
    m_drive = b;
    repeat (5) @(negedge clk);
    bus.mdc = 1'b1;
    repeat (5) @(negedge clk);
    bus.mdc = 1'b0;
  endtask

  task automatic sampleBit(output logic b);
    m_drive = 1'b1;
    repeat (5) @(negedge clk);
    b = bus.mdio_i;
    bus.mdc = 1'b1;
    repeat (5) @(negedge clk);
    bus.mdc = 1'b0;
  endtask

  task automatic sendHeader(input int pre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] regad);
    for (int i = 0; i < pre; i++) mdcBit(1'b1);
    mdcBit(1'b0);
    mdcBit(1'b1);
    for (int i = 1; i >= 0; i--) mdcBit(op[i]);
    for (int i = 4; i >= 0; i--) mdcBit(phy[i]);
    for (int i = 4; i >= 0; i--) mdcBit(regad[i]);
  endtask

  task automatic applyStimulus(input vec_t v, output logic [16:0] rd_bits);
    logic b;
    rd_bits = '0;
    rd_value = v.data;
    sendHeader(v.pre, v.op, v.phy, v.regad);
    if (v.op == OP_READ) begin
      for (int i = 0; i < 18; i++) begin
        sampleBit(b);
        rd_bits = {rd_bits[15:0], b};
      end
    end else begin
      mdcBit(1'b1);
      mdcBit(1'b0);
      for (int i = 15; i >= 0; i--) mdcBit(v.data[i]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic runVector(input vec_t v);
    int we_base, re_base, oe_base;
    logic [16:0] rd_bits;
    we_base = we_cnt;
    re_base = re_cnt;
    oe_base = oe_cnt;
    applyStimulus(v, rd_bits);
    checkOutput({v.name, "_we_count"}, we_cnt - we_base, v.exp_we);
    checkOutput({v.name, "_re_count"}, re_cnt - re_base, v.exp_re);
    if (v.exp_we != 0) begin
      checkOutput({v.name, "_we_addr"}, {27'd0, we_addr}, {27'd0, v.exp_addr});
      checkOutput({v.name, "_wdata"}, {16'd0, we_data}, {16'd0, v.exp_data});
    end
    if (v.exp_re != 0) begin
      checkOutput({v.name, "_re_addr"}, {27'd0, re_addr}, {27'd0, v.exp_addr});
      checkOutput({v.name, "_rd_bits"}, {15'd0, rd_bits}, {15'd0, 1'b0, v.exp_data});
      checkOutput({v.name, "_oe_driven"}, {31'd0, (oe_cnt - oe_base) != 0}, 32'd1);
    end else begin
      checkOutput({v.name, "_oe_quiet"}, oe_cnt - oe_base, 32'd0);
    end
    checkOutput({v.name, "_fa_after"}, {31'd0, bus.frame_active}, 32'd0);
    checkOutput({v.name, "_oe_after"}, {31'd0, bus.mdio_oe}, 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    logic [8:0] part;
    logic b;
    int we_base, re_base;

    vecs[0] = '{"wr_basic",  32, OP_WRITE, 5'h01, 5'h04, 16'h01E1, 1, 0, 5'h04, 16'h01E1};
    vecs[1] = '{"rd_basic",  32, OP_READ,  5'h01, 5'h00, 16'h1200, 0, 1, 5'h00, 16'h1200};
    vecs[2] = '{"wr_phy2",   32, OP_WRITE, 5'h02, 5'h04, 16'h0000, 0, 0, 5'h00, 16'h0000};
    vecs[3] = '{"wr_after",  32, OP_WRITE, 5'h01, 5'h1F, 16'hBEEF, 1, 0, 5'h1F, 16'hBEEF};
`ifdef SMI_PREAMBLE_SUPPRESS_EN
    vecs[4] = '{"wr_pre31",  31, OP_WRITE, 5'h01, 5'h04, 16'h01E1, 1, 0, 5'h04, 16'h01E1};
`else
    vecs[4] = '{"wr_pre31",  31, OP_WRITE, 5'h01, 5'h04, 16'h01E1, 0, 0, 5'h00, 16'h0000};
`endif
    vecs[5] = '{"rd_edges",  32, OP_READ,  5'h01, 5'h11, 16'h8001, 0, 1, 5'h11, 16'h8001};
    vecs[6] = '{"wr_long",   40, OP_WRITE, 5'h01, 5'h02, 16'hFFFF, 1, 0, 5'h02, 16'hFFFF};

    bus.mdc = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_oe", {31'd0, bus.mdio_oe}, 32'd0);
    checkOutput("rst_o", {31'd0, bus.mdio_o}, 32'd0);
    checkOutput("rst_we", {31'd0, bus.reg_we}, 32'd0);
    checkOutput("rst_re", {31'd0, bus.reg_re}, 32'd0);
    checkOutput("rst_fa", {31'd0, bus.frame_active}, 32'd0);
    checkOutput("rst_addr_data", {11'd0, bus.reg_addr, bus.reg_wdata}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) runVector(vecs[i]);

    // Illegal opcode 11: frame_active rises at ST and drops right after OP.
    we_base = we_cnt;
    re_base = re_cnt;
    for (int i = 0; i < 32; i++) mdcBit(1'b1);
    mdcBit(1'b0);
    mdcBit(1'b1);
    checkOutput("op11_fa_in_frame", {31'd0, bus.frame_active}, 32'd1);
    mdcBit(1'b1);
    mdcBit(1'b1);
    checkOutput("op11_fa_after_op", {31'd0, bus.frame_active}, 32'd0);
    checkOutput("op11_no_strobes", (we_cnt - we_base) + (re_cnt - re_base), 32'd0);

    // Reset while the responder is driving data bit 7 of a read.
    rd_value = 16'hC3A5;
    sendHeader(32, OP_READ, 5'h01, 5'h06);
    part = '0;
    for (int i = 0; i < 10; i++) begin
      sampleBit(b);
      part = {part[7:0], b};
    end
    checkOutput("mid_rd_bits", {23'd0, part}, {23'd0, 1'b0, 8'hC3});
    checkOutput("mid_rd_oe", {31'd0, bus.mdio_oe}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_oe", {31'd0, bus.mdio_oe}, 32'd0);
    checkOutput("mid_rst_o", {31'd0, bus.mdio_o}, 32'd0);
    checkOutput("mid_rst_fa", {31'd0, bus.frame_active}, 32'd0);
    checkOutput("mid_rst_strobes", {30'd0, bus.reg_we, bus.reg_re}, 32'd0);
    checkOutput("mid_rst_addr_data", {11'd0, bus.reg_addr, bus.reg_wdata}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    v = '{"rd_post_rst", 32, OP_READ, 5'h01, 5'h09, 16'hA5C3, 0, 1, 5'h09, 16'hA5C3};
    runVector(v);

    checkOutput("we_re_overlap", both_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
